gray_count_sequencer: RTL and testbench

Controller that sequences a run of an N-bit Gray-code counter. Accepts a start command with a binary start value and a step count, advances the counter once per cycle (stallable via pause), and reports completion or abort. It sits between a command source and any logic that consumes Gray-coded counts, replacing free-running Gray counters where bounded, restartable runs are needed.

---
 rtl/gray_count_sequencer.sv | 134 +++++++++++++
 tb/tb_gray_count_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_count_sequencer.sv
// gray_count_sequencer
// Runs a bounded, restartable N-bit counter and presents it in binary and Gray form.
// A start in IDLE loads a binary start value and a step count. The counter then
// advances once per cycle, and pause can stall it. The run finishes with a one-cycle
// DONE, or a stop aborts it early. All outputs are registered. The Gray register
// loads from the next binary value, so it never lags bin_out.
module gray_count_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_ah_in,
  input  logic         start_in,
  input  logic         stop_in,
  input  logic         pause_in,
  input  logic [N-1:0] start_val_in,
  input  logic [N-1:0] len_in,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         step_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         abort_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] C_ZERO = '0;
  localparam logic [N-1:0] C_ONE  = N'(1);

  state_t       r_state;
  logic [N-1:0] r_bin;
  logic [N-1:0] r_gray;
  logic [N-1:0] r_rem;
  logic         r_step;
  logic         r_busy;
  logic         r_done;
  logic         r_abort;

  state_t       w_state_next;
  logic [N-1:0] w_bin_next;
  logic [N-1:0] w_gray_next;
  logic [N-1:0] w_rem_next;
  logic         w_step_next;
  logic         w_busy_next;
  logic         w_done_next;
  logic         w_abort_next;

  // Next-state and next-output decode; RUN priority is stop, then pause, then count.
  always_comb begin
    w_state_next = r_state;
    w_bin_next   = r_bin;
    w_rem_next   = r_rem;
    w_step_next  = 1'b0;
    w_done_next  = 1'b0;
    w_abort_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // stop/pause carry no meaning here, so a start alongside them still loads
        if (start_in) begin
          w_bin_next = start_val_in;
          w_rem_next = len_in;
          if (len_in == C_ZERO) begin
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop_in) begin
          w_state_next = ST_IDLE;
          w_abort_next = 1'b1;
        end else if (!pause_in) begin
          w_bin_next  = r_bin + C_ONE;
          w_rem_next  = r_rem - C_ONE;
          w_step_next = 1'b1;
          // the increment that consumes the last step also lands in DONE
          if (r_rem == C_ONE) begin
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Derived next values: Gray comes from next-bin, busy covers RUN and DONE.
  always_comb begin
    w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    w_busy_next = (w_state_next != ST_IDLE);
  end

  // State and output registers; reset clears everything without any done/abort pulse.
  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_gray  <= '0;
      r_rem   <= '0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_rem   <= w_rem_next;
      r_step  <= w_step_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_abort <= w_abort_next;
    end
  end

  assign bin_out   = r_bin;
  assign gray_out  = r_gray;
  assign step_out  = r_step;
  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign abort_out = r_abort;

endmodule

// File: tb/tb_gray_count_sequencer.sv
// Directed bench for gray_count_sequencer (N=4). Every cycle it compares the packed
// output word {bin, gray, step, busy, done, abort} with a hand-computed expectation.
module tb_gray_count_sequencer;

  logic       clk;
  logic       reset_ah_in;
  logic       start_in;
  logic       stop_in;
  logic       pause_in;
  logic [3:0] start_val_in;
  logic [3:0] len_in;
  logic [3:0] bin_out;
  logic [3:0] gray_out;
  logic       step_out;
  logic       busy_out;
  logic       done_out;
  logic       abort_out;

  int checks   = 0;
  int failures = 0;

  gray_count_sequencer #(.N(4)) dut (
    .clk          (clk),
    .reset_ah_in  (reset_ah_in),
    .start_in     (start_in),
    .stop_in      (stop_in),
    .pause_in     (pause_in),
    .start_val_in (start_val_in),
    .len_in       (len_in),
    .bin_out      (bin_out),
    .gray_out     (gray_out),
    .step_out     (step_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .abort_out    (abort_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [11:0] obs = {bin_out, gray_out, step_out, busy_out, done_out, abort_out};

  // Expected packed word; the gray field is the hand-written Gray code of bin.
  function automatic logic [11:0] exp_word(input logic [3:0] b, input logic [3:0] g,
                                           input logic s, input logic bz,
                                           input logic d, input logic a);
    return {b, g, s, bz, d, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    reset_ah_in  = 1'b1;
    start_in     = 1'($urandom);
    stop_in      = 1'($urandom);
    pause_in     = 1'($urandom);
    start_val_in = 4'($urandom);
    len_in       = 4'($urandom);
    for (int c = 0; c < 2; c++) begin
      tick();
      e = exp_word(4'h0, 4'h0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL reset_c%0d: got %03h expected %03h", c, obs, e); end
    end
    reset_ah_in = 1'b0;
    start_in = 1'b0; stop_in = 1'b0; pause_in = 1'b0;
    tick();
    e = exp_word(4'h0, 4'h0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_idle: got %03h expected %03h", obs, e); end
    $display("txn reset: outputs after reset %03h", obs);
  endtask

  task automatic test_full_run();
    logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [11:0] e;
    int steps = 0;
    int busy_cycles = 0;
    start_val_in = 4'd0; len_in = 4'd15; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    e = exp_word(4'd0, gseq[0], 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL full_start: got %03h expected %03h", obs, e); end
    if (busy_out === 1'b1) busy_cycles++;
    for (int k = 1; k <= 15; k++) begin
      tick();
      e = exp_word(4'(k), gseq[k], 1, 1, (k == 15), 0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL full_k%0d: got %03h expected %03h", k, obs, e); end
      if (step_out === 1'b1) steps++;
      if (busy_out === 1'b1) busy_cycles++;
    end
    tick();
    e = exp_word(4'd15, 4'h8, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL full_end: got %03h expected %03h", obs, e); end
    checks++;
    if (steps != 15 || busy_cycles != 16) begin
      failures++;
      $display("FAIL full_counts: got steps=%0d busy=%0d expected steps=15 busy=16", steps, busy_cycles);
    end
    $display("txn full_run: steps=%0d busy_cycles=%0d", steps, busy_cycles);
  endtask

  task automatic test_wrap();
    logic [3:0] bseq [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [3:0] gseq [4] = '{4'h9, 4'h8, 4'h0, 4'h1};
    logic [11:0] e;
    start_val_in = 4'd14; len_in = 4'd3; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      e = exp_word(bseq[k], gseq[k], (k > 0), 1, (k == 3), 0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL wrap_k%0d: got %03h expected %03h", k, obs, e); end
    end
    tick();
    e = exp_word(4'd1, 4'h1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL wrap_end: got %03h expected %03h", obs, e); end
    $display("txn wrap: final bin=%0d gray=%0h", bin_out, gray_out);
  endtask

  task automatic test_len_zero();
    logic [11:0] e;
    start_val_in = 4'd5; len_in = 4'd0; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    e = exp_word(4'd5, 4'h7, 0, 1, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL len0_done: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd5, 4'h7, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL len0_idle: got %03h expected %03h", obs, e); end
    $display("txn len_zero: bin=%0d gray=%0h", bin_out, gray_out);
  endtask

  task automatic test_stop_pause();
    // per-cycle controls and expectations after the start edge
    logic       pz [7] = '{0, 0, 1, 1, 0, 0, 0};
    logic       sp [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [3:0] eb [7] = '{1, 2, 2, 2, 3, 4, 4};
    logic [3:0] eg [7] = '{4'h1, 4'h3, 4'h3, 4'h3, 4'h2, 4'h6, 4'h6};
    logic       es [7] = '{1, 1, 0, 0, 1, 1, 0};
    logic       ez [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic       ea [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [11:0] e;
    start_val_in = 4'd0; len_in = 4'd10; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    e = exp_word(4'd0, 4'h0, 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL sp_start: got %03h expected %03h", obs, e); end
    for (int c = 0; c < 7; c++) begin
      pause_in = pz[c]; stop_in = sp[c];
      tick();
      e = exp_word(eb[c], eg[c], es[c], ez[c], 0, ea[c]);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL sp_c%0d: got %03h expected %03h", c, obs, e); end
    end
    pause_in = 1'b0; stop_in = 1'b0;
    tick();
    e = exp_word(4'd4, 4'h6, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL sp_after: got %03h expected %03h", obs, e); end
    $display("txn stop_pause: final bin=%0d gray=%0h", bin_out, gray_out);

    // stop on the edge that would have been the final increment
    start_val_in = 4'd0; len_in = 4'd2; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick();
    e = exp_word(4'd1, 4'h1, 1, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL stoplast_step: got %03h expected %03h", obs, e); end
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    e = exp_word(4'd1, 4'h1, 0, 0, 0, 1);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL stoplast_abort: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd1, 4'h1, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL stoplast_idle: got %03h expected %03h", obs, e); end
    $display("txn stop_last: bin=%0d abort seen", bin_out);
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    // start held high for the whole run; only the start sampled in IDLE counts
    start_val_in = 4'd3; len_in = 4'd3; start_in = 1'b1;
    tick();
    start_val_in = 4'd9; len_in = 4'd5;
    e = exp_word(4'd3, 4'h2, 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_start: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd4, 4'h6, 1, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_4: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd5, 4'h7, 1, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_5: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd6, 4'h5, 1, 1, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_done: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd6, 4'h5, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_idle: got %03h expected %03h", obs, e); end
    // start with stop in IDLE: accepted at L+2 spacing
    stop_in = 1'b1;
    tick();
    start_in = 1'b0; stop_in = 1'b0;
    e = exp_word(4'd9, 4'hD, 0, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_restart: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd10, 4'hF, 1, 1, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_10: got %03h expected %03h", obs, e); end
    // reset mid-run: everything clears, no done or abort pulse
    reset_ah_in = 1'b1; stop_in = 1'b1;
    tick();
    reset_ah_in = 1'b0; stop_in = 1'b0;
    e = exp_word(4'd0, 4'h0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL midrst: got %03h expected %03h", obs, e); end
    tick();
    e = exp_word(4'd0, 4'h0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL midrst_after: got %03h expected %03h", obs, e); end
    $display("txn back_to_back: restart and mid-run reset exercised");
  endtask

  initial begin
    reset_ah_in = 1'b1;
    start_in = 1'b0; stop_in = 1'b0; pause_in = 1'b0;
    start_val_in = 4'd0; len_in = 4'd0;
    test_reset();
    test_full_run();
    test_wrap();
    test_len_zero();
    test_stop_pause();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
